aes_dec_arbiter: RTL and testbench

AES_DEC_ARBITER -- requirements
Module: aes_dec_arbiter

---
 rtl/aes_arb_pkg.sv | 12 +
 rtl/aes_dec_arbiter_rr.sv | 23 ++
 rtl/aes_dec_arbiter.sv | 129 ++++++++++++
 tb/tb_aes_dec_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared constants and FSM state encoding for the AES decryption-core arbiter.
package aes_arb_pkg;
  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } arb_state_t;
endpackage

// File: rtl/aes_dec_arbiter_rr.sv
// Round-robin grant: the first asserted request at or after ptr (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/aes_dec_arbiter.sv
// Shares one AES decryption core among NUM_REQ requesters, one job outstanding.
// Optional WAIT-state watchdog enabled by defining AES_ARB_WATCHDOG_EN.
module aes_dec_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0]   req_ciphertext,
  input  logic [NUM_REQ*KEY_W-1:0]     req_key,
  output logic                         core_start,
  output logic [BLOCK_W-1:0]           core_ciphertext,
  output logic [KEY_W-1:0]             core_key,
  input  logic                         core_done,
  input  logic [BLOCK_W-1:0]           core_plaintext,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [BLOCK_W-1:0]           resp_plaintext,
  output logic                         resp_err
);
  localparam int IDW = $clog2(NUM_REQ);

  arb_state_t           state, state_nxt;
  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       grant_id;
  logic [IDW-1:0]       rr_ptr;
  logic                 accept;
  logic                 done_hit;
  logic                 wd_expire;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  assign req_ready  = (state == ST_IDLE) ? grant : '0;
  assign accept     = |(req_valid & req_ready);
  assign core_start = (state == ST_LAUNCH);
  assign resp_valid = (state == ST_RESP);
  // core_done only means something while a job is actually in the core.
  assign done_hit   = (state == ST_WAIT) && core_done;

`ifdef AES_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;
  logic           err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  // A completion landing on the expiry cycle takes precedence over the timeout.
  assign wd_expire = (state == ST_WAIT) && !core_done && (wd_cnt == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (done_hit) begin
      err_q <= 1'b0;
    end else if (wd_expire) begin
      err_q <= 1'b1;
    end
  end
  assign resp_err = err_q;
`else
  assign wd_expire = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (done_hit || wd_expire) state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Operands latch at accept and stay put through LAUNCH and WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_ciphertext <= '0;
      core_key        <= '0;
      resp_id         <= '0;
      rr_ptr          <= '0;
    end else if (accept) begin
      core_ciphertext <= req_ciphertext[BLOCK_W*grant_id +: BLOCK_W];
      core_key        <= req_key[KEY_W*grant_id +: KEY_W];
      resp_id         <= grant_id;
      rr_ptr          <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_plaintext <= '0;
    end else if (done_hit) begin
      resp_plaintext <= core_plaintext;
    end else if (wd_expire) begin
      resp_plaintext <= '0;
    end
  end
endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Directed self-checking bench for aes_dec_arbiter (NUM_REQ=2, TIMEOUT=16).
module tb_aes_dec_arbiter;
  localparam logic [127:0] CT1 = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] K1  = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] P1  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_ciphertext;
  logic [255:0] req_key;
  logic         core_start;
  logic [127:0] core_ciphertext;
  logic [127:0] core_key;
  logic         core_done;
  logic [127:0] core_plaintext;
  logic         resp_valid;
  logic         resp_ready;
  logic [0:0]   resp_id;
  logic [127:0] resp_plaintext;
  logic         resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  aes_dec_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_ciphertext  (req_ciphertext),
    .req_key         (req_key),
    .core_start      (core_start),
    .core_ciphertext (core_ciphertext),
    .core_key        (core_key),
    .core_done       (core_done),
    .core_plaintext  (core_plaintext),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_plaintext  (resp_plaintext),
    .resp_err        (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction; requests stay asserted until the response handshake.
  task automatic do_job(input string tag, input logic [1:0] vld, input logic [1:0] exp_grant,
                        input logic exp_id, input logic [127:0] ct0, input logic [127:0] key0,
                        input logic [127:0] ct1, input logic [127:0] key1,
                        input logic [127:0] exp_ct, input logic [127:0] exp_key,
                        input logic [127:0] pt, input int hold);
    logic [132:0] snap;
    req_valid      = vld;
    req_ciphertext = {ct1, ct0};
    req_key        = {key1, key0};
    #1;
    check({tag, ".grant"}, req_ready, exp_grant);
    tick();
    check({tag, ".launch"}, {core_start, req_ready}, {1'b1, 2'b00});
    check({tag, ".core_ct"}, core_ciphertext, exp_ct);
    check({tag, ".core_key"}, core_key, exp_key);
    tick();
    check({tag, ".wait"}, {core_start, req_ready, resp_valid}, 4'b0000);
    tick();
    core_done      = 1'b1;
    core_plaintext = pt;
    tick();
    core_done      = 1'b0;
    core_plaintext = ~pt;
    check({tag, ".core_ops_held"}, {core_ciphertext, core_key}, {exp_ct, exp_key});
    snap = {1'b1, exp_id, pt, 2'b00, 1'b0};
    check({tag, ".resp"}, {resp_valid, resp_id, resp_plaintext, req_ready, core_start}, snap);
    check({tag, ".err"}, resp_err, 1'b0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold"}, {resp_valid, resp_id, resp_plaintext, req_ready, core_start}, snap);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    req_valid  = 2'b00;
    check({tag, ".resp_done"}, resp_valid, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = '0;
    req_ciphertext = '0;
    req_key        = '0;
    core_done      = 1'b0;
    core_plaintext = '0;
    resp_ready     = 1'b0;
    tick();
    tick();
    check("reset_outs", {req_ready, core_start, resp_valid, resp_err, resp_id}, 5'b0);
    check("reset_data", {resp_plaintext, core_ciphertext[31:0]}, 160'b0);
    check("reset_key", core_key, 128'b0);
    reset = 1'b0;
    tick();

    // Single job from requester 0; slot 1 carries different data that must not leak.
    do_job("single", 2'b01, 2'b01, 1'b0, CT1, K1, ~CT1, ~K1, CT1, K1, P1, 0);

    // Pointer now favours requester 1; hold response for 20 cycles.
    do_job("backpr", 2'b11, 2'b10, 1'b1, CT1, K1, CT2, K2, CT2, K2, P2, 20);

    // Spurious core_done while idle.
    core_done      = 1'b1;
    core_plaintext = P1;
    tick();
    core_done = 1'b0;
    check("spurious_idle", {resp_valid, core_start, req_ready}, 4'b0);
    tick();
    check("spurious_idle2", resp_valid, 1'b0);

    // Reset while in WAIT.
    req_valid      = 2'b10;
    req_ciphertext = {CT2, CT1};
    req_key        = {K2, K1};
    tick();
    tick();
    req_valid = 2'b00;
    check("pre_reset_wait", {core_start, resp_valid, core_ciphertext}, {2'b00, CT2});
    #2 reset = 1'b1;
    #1;
    check("reset_mid", {core_start, resp_valid, resp_err, resp_id, req_ready}, 6'b0);
    check("reset_mid_ops", {core_ciphertext, resp_plaintext[31:0]}, 160'b0);
    check("reset_mid_key", core_key, 128'b0);
    @(negedge clk);
    reset          = 1'b0;
    core_done      = 1'b1;
    core_plaintext = P2;
    tick();
    core_done = 1'b0;
    check("stray_done", {resp_valid, core_start}, 2'b00);
    tick();
    check("stray_done2", resp_valid, 1'b0);

    // Contention after reset: strict alternation starting at requester 0.
    do_job("cont0", 2'b11, 2'b01, 1'b0, CT2, K2, CT2, K2, CT2, K2, P2, 0);
    do_job("cont1", 2'b11, 2'b10, 1'b1, CT2, K2, CT2, K2, CT2, K2, P2, 0);
    do_job("cont2", 2'b11, 2'b01, 1'b0, CT2, K2, CT2, K2, CT2, K2, P2, 0);
    do_job("cont3", 2'b11, 2'b10, 1'b1, CT2, K2, CT2, K2, CT2, K2, P2, 0);

`ifdef AES_ARB_WATCHDOG_EN
    // Core never completes: error response after 16 WAIT cycles.
    req_valid      = 2'b01;
    req_ciphertext = {CT1, CT1};
    req_key        = {K1, K1};
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("wd_waiting", resp_valid, 1'b0);
      tick();
    end
    check("wd_resp", {resp_valid, resp_err, resp_id, resp_plaintext}, {1'b1, 1'b1, 1'b0, 128'b0});
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("wd_done", {resp_valid, resp_err}, 2'b01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
